// File: rtl/tb_wait_pkg.sv
// Shared types and defaults for the testbench wait-event observer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package tb_wait_pkg;

  // Defaults shared with tb_top so the alias bus shape is declared in one place.
  localparam int WAIT_ALIAS_NB_DEF = 5;
  localparam int WAIT_WIDTH_DEF    = 32;

  typedef enum logic [2:0] {
    RISE     = 3'd0,
    FALL     = 3'd1,
    LVL_HIGH = 3'd2,
    LVL_LOW  = 3'd3,
    VALUE_EQ = 3'd4
  } wait_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } wait_state_t;

  // Codes 5..7 have no meaning and are reported as errors.
  function automatic logic type_legal(input logic [2:0] t);
    return (t <= 3'd4);
  endfunction

endpackage

// File: rtl/tb_wait_timer.sv
// Loadable down-counter for wait timeouts; a load value of 0 never expires.
// Latency: expire is combinational from the count; load/decrement take effect next edge.
// Backpressure: none; decrement only while en is high and the count is above 1.
//
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load       : load load_val this cycle (wins over en)
//   load_val   : timeout in cycles, 0 = infinite
//   en         : decrement request
//   expire     : high while the count sits at 1 (last allowed cycle)
module tb_wait_timer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             expire
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q > WIDTH'(1))) begin
      // Stopping at 1 keeps the unsigned count from ever wrapping, and a
      // count of 0 is left alone so it behaves as "no timeout".
      cnt_q <= cnt_q - WIDTH'(1);
    end
  end

  assign expire = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/tb_wait_event.sv
// Watches one selected alias of the i_wait bus for an edge, level or value and
// reports done/timeout/err. Latency: err at T+1, earliest done at T+3 after accept.
// Backpressure: o_cmd_ready only in IDLE; i_cmd_valid while busy is simply not taken.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready : command handshake
//   i_cmd_sel/type/value/timeout : alias index, wait_type_t code, compare word, cycle limit (0 = none)
//   i_abort             : drop the pending wait without a pulse
//   i_wait              : observed alias words
//   o_busy              : a wait is armed or running
//   o_done/o_timeout/o_err : mutually exclusive one-cycle result pulses
module tb_wait_event
  import tb_wait_pkg::*;
#(
  parameter int WAIT_ALIAS_NB = WAIT_ALIAS_NB_DEF,
  parameter int WAIT_WIDTH    = WAIT_WIDTH_DEF,
  parameter int TIMEOUT_WIDTH = 32,
  parameter int SEL_WIDTH     = $clog2(WAIT_ALIAS_NB)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_cmd_valid,
  output logic                     o_cmd_ready,
  input  logic [SEL_WIDTH-1:0]     i_cmd_sel,
  input  logic [2:0]               i_cmd_type,
  input  logic [WAIT_WIDTH-1:0]    i_cmd_value,
  input  logic [TIMEOUT_WIDTH-1:0] i_cmd_timeout,
  input  logic                     i_abort,
  input  logic [WAIT_WIDTH-1:0]    i_wait [WAIT_ALIAS_NB],
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_timeout,
  output logic                     o_err
);

  wait_state_t               state_q, state_d;
  logic [SEL_WIDTH-1:0]      sel_q;
  wait_type_t                type_q;
  logic [WAIT_WIDTH-1:0]     value_q;
  logic [TIMEOUT_WIDTH-1:0]  timeout_q;
  logic                      prev_q;
  logic                      done_q, timeout_pulse_q, err_q;
  logic                      done_d, timeout_d, err_d;

  logic [WAIT_WIDTH-1:0]     cur;
  logic                      met;
  logic                      accept;
  logic                      cmd_bad;
  logic                      timer_load;
  logic                      timer_en;
  logic                      timer_expire;

  assign accept  = i_cmd_valid && o_cmd_ready;
  assign cmd_bad = (int'(i_cmd_sel) >= WAIT_ALIAS_NB) || !type_legal(i_cmd_type);

  // Alias mux driven by the latched select; out-of-range selects never reach
  // ARM/WAIT, so the zero default is never observed there.
  always_comb begin
    cur = '0;
    for (int i = 0; i < WAIT_ALIAS_NB; i++) begin
      if (sel_q == SEL_WIDTH'(i)) cur = i_wait[i];
    end
  end

  // Edge types compare against the bit seen one cycle earlier; prev is
  // seeded in ARM, so an edge needs a real transition after arming.
  always_comb begin
    met = 1'b0;
    case (type_q)
      RISE:     met = !prev_q && cur[0];
      FALL:     met = prev_q && !cur[0];
      LVL_HIGH: met = cur[0];
      LVL_LOW:  met = !cur[0];
      VALUE_EQ: met = (cur == value_q);
      default:  met = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Priority inside WAIT: abort, then done, then timeout.
  always_comb begin
    state_d   = state_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (cmd_bad) begin
            state_d = RESP;
            err_d   = 1'b1;
          end else begin
            state_d = ARM;
          end
        end
      end
      ARM: begin
        state_d = i_abort ? IDLE : WAIT;
      end
      WAIT: begin
        if (i_abort) begin
          state_d = IDLE;
        end else if (met) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (timer_expire) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q           <= '0;
      type_q          <= RISE;
      value_q         <= '0;
      timeout_q       <= '0;
      prev_q          <= 1'b0;
      done_q          <= 1'b0;
      timeout_pulse_q <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_q          <= done_d;
      timeout_pulse_q <= timeout_d;
      err_q           <= err_d;
      if (accept) begin
        sel_q     <= i_cmd_sel;
        value_q   <= i_cmd_value;
        timeout_q <= i_cmd_timeout;
        if (!cmd_bad) type_q <= wait_type_t'(i_cmd_type);
      end
      if (state_q == ARM || state_q == WAIT) prev_q <= cur[0];
    end
  end

  assign timer_load = (state_q == ARM);
  assign timer_en   = (state_q == WAIT) && !met;

  tb_wait_timer #(
    .WIDTH (TIMEOUT_WIDTH)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timeout_q),
    .en       (timer_en),
    .expire   (timer_expire)
  );

  assign o_cmd_ready = (state_q == IDLE);
  assign o_busy      = (state_q == ARM) || (state_q == WAIT);
  assign o_done      = done_q;
  assign o_timeout   = timeout_pulse_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_tb_wait_event.sv
// Directed bench for tb_wait_event: edge, level, value, timeout, error,
// abort and reset cases with hand-computed cycle expectations.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_tb_wait_event;

  localparam int NB = 5;
  localparam int W  = 32;
  localparam int TW = 32;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [SW-1:0] cmd_sel;
  logic [2:0]    cmd_type;
  logic [W-1:0]  cmd_value;
  logic [TW-1:0] cmd_timeout;
  logic          abort;
  logic [W-1:0]  wait_bus [NB];
  logic          busy, done, tmo, err;

  int n_pass  = 0;
  int n_total = 0;

  tb_wait_event #(
    .WAIT_ALIAS_NB (NB),
    .WAIT_WIDTH    (W),
    .TIMEOUT_WIDTH (TW),
    .SEL_WIDTH     (SW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_sel     (cmd_sel),
    .i_cmd_type    (cmd_type),
    .i_cmd_value   (cmd_value),
    .i_cmd_timeout (cmd_timeout),
    .i_abort       (abort),
    .i_wait        (wait_bus),
    .o_busy        (busy),
    .o_done        (done),
    .o_timeout     (tmo),
    .o_err         (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Outputs as {ready, busy, done, timeout, err}.
  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, cmd_ready, busy, done, tmo, err}, {27'd0, exp});
  endtask

  task automatic issue(input logic [SW-1:0] sel, input logic [2:0] typ,
                       input logic [W-1:0] val, input logic [TW-1:0] to);
    cmd_sel     = sel;
    cmd_type    = typ;
    cmd_value   = val;
    cmd_timeout = to;
    cmd_valid   = 1'b1;
    step();            // accept edge; now in cycle T+1
    cmd_valid   = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_sel     = '0;
    cmd_type    = '0;
    cmd_value   = '0;
    cmd_timeout = '0;
    abort       = 1'b0;
    for (int i = 0; i < NB; i++) wait_bus[i] = '0;

    step();
    step();
    chk_out("reset_outputs", 5'b10000);
    rst_n = 1'b1;
    step();
    chk_out("idle_after_reset", 5'b10000);

    // RISE on alias 2, no timeout; edge lands in the 5th WAIT cycle.
    issue(3'd2, 3'd0, '0, '0);
    chk_out("rise_arm", 5'b01000);
    step();                                   // WAIT1
    for (int k = 1; k < 5; k++) begin
      chk_out("rise_waiting", 5'b01000);
      step();
    end
    wait_bus[2] = 32'h1;                      // WAIT5
    chk_out("rise_wait5", 5'b01000);
    step();
    chk_out("rise_done", 5'b10100);
    step();
    chk_out("rise_done_single", 5'b10000);
    wait_bus[2] = '0;

    // VALUE_EQ alias 0, timeout 10, value never appears.
    issue(3'd0, 3'd4, 32'hDEAD_BEEF, 32'd10);
    step();                                   // WAIT1
    for (int k = 1; k < 10; k++) begin
      chk_out("veq_waiting", 5'b01000);
      step();
    end
    chk_out("veq_wait10", 5'b01000);
    step();
    chk_out("veq_timeout", 5'b10010);
    step();
    chk_out("veq_timeout_single", 5'b10000);

    // LVL_HIGH alias 4 already high at accept: done at T+3.
    wait_bus[4] = 32'h1;
    issue(3'd4, 3'd2, '0, '0);
    chk_out("lvl_t1", 5'b01000);
    step();
    chk_out("lvl_t2", 5'b01000);
    step();
    chk_out("lvl_t3_done", 5'b10100);
    wait_bus[4] = '0;

    // FALL alias 1, timeout 3, edge on the last allowed cycle: done wins.
    wait_bus[1] = 32'h1;
    issue(3'd1, 3'd1, '0, 32'd3);
    step();                                   // WAIT1
    chk_out("fall_w1", 5'b01000);
    step();                                   // WAIT2
    chk_out("fall_w2", 5'b01000);
    step();                                   // WAIT3
    wait_bus[1] = '0;
    step();
    chk_out("fall_done_wins", 5'b10100);
    step();
    chk_out("fall_quiet", 5'b10000);

    // Illegal select, then illegal type.
    issue(3'd7, 3'd0, '0, '0);
    chk_out("bad_sel_err", 5'b00001);
    step();
    chk_out("bad_sel_ready", 5'b10000);
    issue(3'd0, 3'd6, '0, '0);
    chk_out("bad_type_err", 5'b00001);
    step();
    chk_out("bad_type_ready", 5'b10000);

    // Abort mid-WAIT, coinciding with a rising edge: abort wins.
    issue(3'd3, 3'd0, '0, '0);
    step();
    step();                                   // WAIT2
    abort       = 1'b1;
    wait_bus[3] = 32'h1;
    step();
    chk_out("abort_idle", 5'b10000);
    abort       = 1'b0;
    wait_bus[3] = '0;
    step();
    chk_out("abort_no_pulse", 5'b10000);

    // Reset mid-WAIT drops the wait silently.
    issue(3'd3, 3'd0, '0, 32'd5);
    step();                                   // WAIT1
    chk_out("pre_reset_wait", 5'b01000);
    rst_n = 1'b0;
    step();
    chk_out("mid_reset", 5'b10000);
    rst_n = 1'b1;
    step();
    chk_out("post_reset", 5'b10000);

    // Fresh RISE completes normally; then back-to-back bad command on done.
    issue(3'd3, 3'd0, '0, '0);
    step();                                   // WAIT1
    wait_bus[3] = 32'h1;
    chk_out("rerun_wait1", 5'b01000);
    cmd_sel   = 3'd5;
    cmd_type  = 3'd0;
    step();
    chk_out("rerun_done", 5'b10100);
    cmd_valid = 1'b1;                         // accepted in the done cycle
    step();
    cmd_valid = 1'b0;
    chk_out("b2b_err", 5'b00001);
    step();
    chk_out("b2b_ready", 5'b10000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
